// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the keypad operand loader.
package operand_loader_pkg;
  localparam int NIBBLE_W = 4;
  localparam int KEYS     = 16;

  typedef enum logic [1:0] {
    S_XH = 2'd0,
    S_XL = 2'd1,
    S_YH = 2'd2,
    S_YL = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [KEYS-1:0] k);
    return (k != '0) && ((k & (k - KEYS'(1))) == '0);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: samples the raw pattern, waits for it to hold, and
// accepts a single one-hot key once per press (re-armed by a stable release).
module key_debounce
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEYS-1:0]     key_i,
  output logic                accept,
  output logic [NIBBLE_W-1:0] digit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [KEYS-1:0] key_q;
  logic [CW-1:0]   cnt_q;
  logic            armed_q;
  logic            stable;

  assign stable = (cnt_q == CNT_MAX);
  assign accept = stable && armed_q && is_onehot(key_q);

  always_comb begin
    digit = '0;
    for (int i = 0; i < KEYS; i++)
      if (key_q[i]) digit = NIBBLE_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (key_i != key_q) begin
        key_q <= key_i;
        cnt_q <= '0;
      end else if (!stable) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Any stable non-zero pattern disarms: one-hot via acceptance, multi-key
      // silently. Only a stable release re-arms.
      if (stable) armed_q <= (key_q == '0);
    end
  end
endmodule

// File: rtl/operand_loader.sv
// Collects four debounced hex digits into operands X and Y for the ALU stage.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] key_out,
  input  logic        clr,
  output logic [7:0]  X,
  output logic [7:0]  Y,
  output logic [1:0]  digit_idx,
  output logic        key_evt,
  output logic        operands_valid
);
  logic                accept;
  logic [NIBBLE_W-1:0] digit;

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic       evt_q, evt_d, ov_q, ov_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .key_i (key_out),
    .accept(accept),
    .digit (digit)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    evt_d   = 1'b0;
    ov_d    = 1'b0;
    // clr wins over a same-cycle acceptance; the debouncer still consumes it.
    if (clr) begin
      state_d = S_XH;
      x_d     = '0;
      y_d     = '0;
    end else if (accept) begin
      evt_d = 1'b1;
      case (state_q)
        S_XH: begin x_d = {digit, {NIBBLE_W{1'b0}}}; state_d = S_XL; end
        S_XL: begin x_d[NIBBLE_W-1:0] = digit;       state_d = S_YH; end
        S_YH: begin y_d = {digit, {NIBBLE_W{1'b0}}}; state_d = S_YL; end
        S_YL: begin y_d[NIBBLE_W-1:0] = digit; ov_d = 1'b1; state_d = S_XH; end
        default: state_d = S_XH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_XH;
      x_q     <= '0;
      y_q     <= '0;
      evt_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      evt_q   <= evt_d;
      ov_q    <= ov_d;
    end
  end

  assign X              = x_q;
  assign Y              = y_q;
  assign digit_idx      = state_q;
  assign key_evt        = evt_q;
  assign operands_valid = ov_q;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window.
module tb_operand_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_out;
  logic        clr;
  logic [7:0]  X, Y;
  logic [1:0]  digit_idx;
  logic        key_evt, operands_valid;

  int tests = 0;
  int fails = 0;

  operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_out(key_out), .clr(clr),
    .X(X), .Y(Y), .digit_idx(digit_idx),
    .key_evt(key_evt), .operands_valid(operands_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] key;
    logic        clr;
    int          cyc;
    logic [7:0]  x, y;
    logic [1:0]  idx;
    int          evts, ovs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic [15:0] k, input logic c, input int cy,
                     input logic [7:0] x, input logic [7:0] y, input logic [1:0] idx,
                     input int ev, input int ov);
    vec_t v;
    v.name = n; v.key = k; v.clr = c; v.cyc = cy;
    v.x = x; v.y = y; v.idx = idx; v.evts = ev; v.ovs = ov;
    tbl.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Drive for n cycles, counting key_evt / operands_valid pulses seen after each edge.
  task automatic run(input logic [15:0] k, input logic c, input int n,
                     output int ne, output int no);
    ne = 0; no = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_out = k;
      clr     = c;
      @(posedge clk);
      #1;
      if (key_evt === 1'b1) ne++;
      if (operands_valid === 1'b1) no++;
    end
  endtask

  task automatic chk_state(input string n, input logic [7:0] x, input logic [7:0] y,
                           input logic [1:0] idx);
    chk({n, ".X"}, 32'(X), 32'(x));
    chk({n, ".Y"}, 32'(Y), 32'(y));
    chk({n, ".idx"}, 32'(digit_idx), 32'(idx));
  endtask

  initial begin
    int ne, no;
    rst_n = 1'b0; key_out = '0; clr = 1'b0;
    run(16'h0000, 1'b0, 2, ne, no);
    chk_state("reset", 8'h00, 8'h00, 2'd0);
    chk("reset.evt", 32'(key_evt), 32'd0);
    chk("reset.ov", 32'(operands_valid), 32'd0);
    rst_n = 1'b1;

    // clean entry 3,A,5,C
    add("idle",   16'h0000, 0, 6, 8'h00, 8'h00, 2'd0, 0, 0);
    add("k3",     16'h0008, 0, 6, 8'h30, 8'h00, 2'd1, 1, 0);
    add("r3",     16'h0000, 0, 6, 8'h30, 8'h00, 2'd1, 0, 0);
    add("kA",     16'h0400, 0, 6, 8'h3A, 8'h00, 2'd2, 1, 0);
    add("rA",     16'h0000, 0, 6, 8'h3A, 8'h00, 2'd2, 0, 0);
    add("k5",     16'h0020, 0, 6, 8'h3A, 8'h50, 2'd3, 1, 0);
    add("r5",     16'h0000, 0, 6, 8'h3A, 8'h50, 2'd3, 0, 0);
    add("kC",     16'h1000, 0, 6, 8'h3A, 8'h5C, 2'd0, 1, 1);
    add("rC",     16'h0000, 0, 6, 8'h3A, 8'h5C, 2'd0, 0, 0);
    // bounce on key 3, then hold
    for (int i = 0; i < 3; i++) begin
      add("bounceH", 16'h0008, 0, 2, 8'h3A, 8'h5C, 2'd0, 0, 0);
      add("bounceL", 16'h0000, 0, 2, 8'h3A, 8'h5C, 2'd0, 0, 0);
    end
    add("bhold",  16'h0008, 0, 8, 8'h30, 8'h5C, 2'd1, 1, 0);
    add("brel",   16'h0000, 0, 6, 8'h30, 8'h5C, 2'd1, 0, 0);
    // long hold on key 7
    add("k7long", 16'h0080, 0, 100, 8'h37, 8'h5C, 2'd2, 1, 0);
    add("r7",     16'h0000, 0, 6, 8'h37, 8'h5C, 2'd2, 0, 0);
    // two keys together are ignored
    add("multi",  16'h0011, 0, 20, 8'h37, 8'h5C, 2'd2, 0, 0);
    add("rmulti", 16'h0000, 0, 6, 8'h37, 8'h5C, 2'd2, 0, 0);
    add("k1",     16'h0002, 0, 6, 8'h37, 8'h10, 2'd3, 1, 0);
    add("r1",     16'h0000, 0, 6, 8'h37, 8'h10, 2'd3, 0, 0);
    // clear, enter 1,2,3, clear
    add("clr0",   16'h0000, 1, 1, 8'h00, 8'h00, 2'd0, 0, 0);
    add("e1",     16'h0002, 0, 6, 8'h10, 8'h00, 2'd1, 1, 0);
    add("re1",    16'h0000, 0, 6, 8'h10, 8'h00, 2'd1, 0, 0);
    add("e2",     16'h0004, 0, 6, 8'h12, 8'h00, 2'd2, 1, 0);
    add("re2",    16'h0000, 0, 6, 8'h12, 8'h00, 2'd2, 0, 0);
    add("e3",     16'h0008, 0, 6, 8'h12, 8'h30, 2'd3, 1, 0);
    add("re3",    16'h0000, 0, 6, 8'h12, 8'h30, 2'd3, 0, 0);
    add("clr1",   16'h0000, 1, 1, 8'h00, 8'h00, 2'd0, 0, 0);

    foreach (tbl[i]) begin
      run(tbl[i].key, tbl[i].clr, tbl[i].cyc, ne, no);
      chk_state(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].idx);
      chk({tbl[i].name, ".evts"}, 32'(ne), 32'(tbl[i].evts));
      chk({tbl[i].name, ".ovs"}, 32'(no), 32'(tbl[i].ovs));
    end

    // Exact acceptance edge: key 5 first sampled at edge 0, accepted at edge 4.
    run(16'h0020, 1'b0, 4, ne, no);
    chk("edge.pre_evts", 32'(ne), 32'd0);
    chk_state("edge.pre", 8'h00, 8'h00, 2'd0);
    // clr on the acceptance edge drops the digit and consumes the press.
    run(16'h0020, 1'b1, 1, ne, no);
    chk("clracc.evts", 32'(ne), 32'd0);
    chk_state("clracc", 8'h00, 8'h00, 2'd0);
    run(16'h0020, 1'b0, 10, ne, no);
    chk("clracc.hold_evts", 32'(ne), 32'd0);
    chk_state("clracc.hold", 8'h00, 8'h00, 2'd0);
    run(16'h0000, 1'b0, 6, ne, no);
    run(16'h0020, 1'b0, 4, ne, no);
    chk("repress.pre_evts", 32'(ne), 32'd0);
    run(16'h0020, 1'b0, 1, ne, no);
    chk("repress.evt_edge", 32'(ne), 32'd1);
    chk_state("repress", 8'h50, 8'h00, 2'd1);
    run(16'h0020, 1'b0, 1, ne, no);
    chk("repress.pulse_width", 32'(ne), 32'd0);
    run(16'h0000, 1'b0, 6, ne, no);

    // Reset while key 9 is held: needs release and re-press.
    rst_n = 1'b0;
    run(16'h0200, 1'b0, 2, ne, no);
    rst_n = 1'b1;
    chk("rst9.evts", 32'(ne), 32'd0);
    chk_state("rst9", 8'h00, 8'h00, 2'd0);
    run(16'h0200, 1'b0, 12, ne, no);
    chk("rst9.hold_evts", 32'(ne), 32'd0);
    chk_state("rst9.hold", 8'h00, 8'h00, 2'd0);
    run(16'h0000, 1'b0, 6, ne, no);
    run(16'h0200, 1'b0, 6, ne, no);
    chk("rst9.repress_evts", 32'(ne), 32'd1);
    chk_state("rst9.repress", 8'h90, 8'h00, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
